// File: rtl/shift_mix_stage.sv
// rtl/shift_mix_stage.sv - AES ShiftRows + MixColumns stage with an in-order result FIFO.
// Define SHIFT_MIX_PIPE_EN to register ShiftRows before MixColumns (latency 2, DEPTH 3).
module shift_mix_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

`ifdef SHIFT_MIX_PIPE_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 2;
`endif
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [1:0]    DEPTH_C  = 2'(DEPTH);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c + rw) % 4) + rw) -: 8];
      end
    end
    return r;
  endfunction

  // 02*a ^ 03*b folds to xtime(a ^ b) ^ b, so each output byte needs one xtime.
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 8] = xtime(a0 ^ a1) ^ a1 ^ a2 ^ a3;
      r[119 - 32*c -: 8] = xtime(a1 ^ a2) ^ a2 ^ a3 ^ a0;
      r[111 - 32*c -: 8] = xtime(a2 ^ a3) ^ a3 ^ a0 ^ a1;
      r[103 - 32*c -: 8] = xtime(a3 ^ a0) ^ a0 ^ a1 ^ a2;
    end
    return r;
  endfunction

  logic [1:0]    occ_q, occ_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [127:0]  mem_q [DEPTH];
  logic          in_fire, out_fire, wr_en;
  logic [127:0]  sr_data, wr_data;

  // occ_q includes words still in the datapath, so the FIFO can never overflow.
  assign in_ready  = (occ_q < DEPTH_C);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign sr_data   = shift_rows(in_data);

`ifdef SHIFT_MIX_PIPE_EN
  logic         st_valid_q;
  logic         st_last_q;
  logic [127:0] st_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_valid_q <= 1'b0;
      st_last_q  <= 1'b0;
      st_data_q  <= '0;
    end else begin
      st_valid_q <= in_fire;
      if (in_fire) begin
        st_data_q <= sr_data;
        st_last_q <= in_last;
      end
    end
  end

  assign wr_en   = st_valid_q;
  assign wr_data = st_last_q ? st_data_q : mix_columns(st_data_q);
`else
  assign wr_en   = in_fire;
  assign wr_data = in_last ? sr_data : mix_columns(sr_data);
`endif

  always_comb begin
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (in_fire && !out_fire) occ_d = occ_q + 2'd1;
    else if (!in_fire && out_fire) occ_d = occ_q - 2'd1;
    if (wr_en && !out_fire) cnt_d = cnt_q + 2'd1;
    else if (!wr_en && out_fire) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q    <= 2'd0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      if (wr_en)    wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (out_fire) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: validity is carried entirely by cnt_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_shift_mix_stage.sv
// tb/tb_shift_mix_stage.sv - self-checking bench for shift_mix_stage (honours SHIFT_MIX_PIPE_EN).
module tb_shift_mix_stage;

`ifdef SHIFT_MIX_PIPE_EN
  localparam int LAT = 2;
  localparam int DEPTH = 3;
`else
  localparam int LAT = 1;
  localparam int DEPTH = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_last, out_valid, out_ready;
  logic [127:0] in_data, out_data;

  shift_mix_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    int           rdy;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   s_in_ready, s_out_valid;
  int   acc, outs, lows;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [7:0] p;
    p = 8'h00;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic last);
    logic [7:0]   st[4][4];
    logic [7:0]   sr[4][4];
    logic [7:0]   o[4][4];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) st[k % 4][k / 4] = d[127 - 8*k -: 8];
    for (int rw = 0; rw < 4; rw++)
      for (int c = 0; c < 4; c++) sr[rw][c] = st[rw][(c + rw) % 4];
    for (int rw = 0; rw < 4; rw++)
      for (int c = 0; c < 4; c++)
        o[rw][c] = last ? sr[rw][c]
                        : gmul(8'h02, sr[rw][c]) ^ gmul(8'h03, sr[(rw + 1) % 4][c])
                          ^ sr[(rw + 2) % 4][c] ^ sr[(rw + 3) % 4][c];
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = o[k % 4][k / 4];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, update the model at the rising edge.
  task automatic tick();
    bit exp_ov, exp_ir, infire, outfire;
    @(negedge clk);
    exp_ir = (q.size() < DEPTH);
    exp_ov = (q.size() > 0) && (q[0].rdy <= cyc);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ir});
    chk("out_valid", {127'd0, out_valid}, {127'd0, exp_ov});
    if (exp_ov) chk("out_data", out_data, q[0].d);
    infire  = in_valid && exp_ir;
    outfire = exp_ov && out_ready;
    @(posedge clk);
    cyc++;
    if (outfire) void'(q.pop_front());
    if (infire) q.push_back('{ref_round(in_data, in_last), cyc + LAT - 1});
    #1;
  endtask

  task automatic directed(input logic [127:0] d, input logic l, input logic [127:0] expc);
    in_valid = 1'b1; in_data = d; in_last = l; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_data = ~d; in_last = ~l;
    repeat (LAT - 1) tick();
    chk("directed_const", out_data, expc);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_data", out_data, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    directed(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);
    directed(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    directed('0, 1'b0, '0);
    directed('1, 1'b0, '1);

    // Backpressure: exactly DEPTH words enter, then drain in order.
    acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      in_valid = 1'b1; in_last = 1'($urandom_range(0, 1));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (s_in_ready) acc++;
    end
    chk("bp_accepted", 128'(acc), 128'(DEPTH));
    in_valid = 1'b0; out_ready = 1'b1; outs = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      tick();
      if (s_out_valid) outs++;
    end
    chk("bp_drained", 128'(outs), 128'(DEPTH));

    // Streaming: 8 back-to-back words.
    outs = 0; lows = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_last = 1'($urandom_range(0, 1));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (!s_in_ready) lows++;
      if (s_out_valid) outs++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (s_out_valid) outs++;
    end
    chk("stream_in_ready_low", 128'(lows), 128'd0);
    chk("stream_out_count", 128'(outs), 128'd8);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_last = 1'($urandom_range(0, 1));
      end else begin
        in_data = 'x; in_last = 1'bx;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset mid-operation with two words held.
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("midrst_out_data", out_data, 128'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (LAT + 3) tick();
    directed(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_mix_stage.md
SHIFT_MIX_STAGE -- requirements
Module: shift_mix_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  in_data/in_last valid this cycle.
REQ-004 in_ready  output  1  block can accept a word this cycle.
REQ-005 in_data  input  128  SubBytes output; column-major bytes, byte k = bits [127-8k -: 8], row r = k mod 4, col c = k div 4.
REQ-006 in_last  input  1  final AES round: apply ShiftRows only, skip MixColumns.
REQ-007 out_valid  output  1  out_data holds a result.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_data  output  128  result, same byte ordering as in_data.

Function
REQ-010 Input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-011 ShiftRows: row r rotated left by r byte positions (r=0..3).
REQ-012 MixColumns: per column, GF(2^8) product with circulant matrix [02 03 01 01]; reduction polynomial 0x11B; xtime(b) = (b<<1) XOR (b[7] ? 0x1B : 0).
REQ-013 in_last=1: out_data = ShiftRows(in_data); in_last=0: out_data = MixColumns(ShiftRows(in_data)); in_last travels with its own word.
REQ-014 Latency from input transfer to out_valid for that word: 1 cycle (macro undefined), 2 cycles (macro defined).
REQ-015 Results buffered in an in-order output FIFO of DEPTH entries: DEPTH=2 (macro undefined), 3 (macro defined).
REQ-016 Occupancy counter counts words accepted and not yet output-transferred, including words in flight.
REQ-017 in_ready = (occupancy < DEPTH), derived from registered state only; no combinational path from out_ready or in_valid to in_ready.
REQ-018 out_valid = 1 whenever the FIFO head holds a completed result; out_data stable while out_valid=1 and out_ready=0.
REQ-019 Same-cycle input and output transfer: occupancy unchanged, both words handled, no loss or duplication.
REQ-020 Full (occupancy=DEPTH): in_ready=0; in_valid ignored; no input transfer.
REQ-021 Empty: out_valid=0; out_ready ignored.
REQ-022 in_data/in_last ignored when in_valid=0; X on them with in_valid=0 never propagates.
REQ-023 Sustained throughput: one word per cycle when out_ready held at 1.
REQ-024 Words leave in acceptance order.

Reset
REQ-025 rst_n low: immediately out_valid=0, out_data=0, occupancy=0, in_ready=1, FIFO and pipeline contents discarded.
REQ-026 Reset mid-operation: all in-flight/buffered words dropped; no output transfer of pre-reset words after release.
REQ-027 First input transfer possible on first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SHIFT_MIX_PIPE_EN defined: ShiftRows result registered in an extra stage before MixColumns; latency 2, DEPTH 3, throughput unchanged.
REQ-029 Macro SHIFT_MIX_PIPE_EN undefined: ShiftRows and MixColumns in one combinational stage; latency 1, DEPTH 2.

Verification
REQ-030 FIPS-197 B round 1: in_data=d42711aee0bf98f1b8b45de51e415230, in_last=0, out_ready=1 -> out_data=046681e5e0cb199a48f8d37a2806264c after configured latency.
REQ-031 Same in_data, in_last=1 -> out_data=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-032 All-zero in_data, in_last=0 -> out_data=0; all-ff in_data -> all-ff.
REQ-033 Backpressure: out_ready=0, in_valid=1 continuous -> exactly DEPTH words accepted, then in_ready=0; out_data stable; releasing out_ready drains DEPTH words in order.
REQ-034 Streaming: 8 back-to-back words with out_ready=1 -> 8 consecutive out_valid cycles, correct order, in_ready never low.
REQ-035 Reset mid-op: 2 words accepted, rst_n pulsed low before output -> out_valid=0, in_ready=1, no stale word ever appears.
